// File: rtl/frame_pkg.sv
// frame_pkg: frame layout shared by the packer and its downstream consumer
package frame_pkg;
  localparam int N_BYTES = 8;
  localparam int BYTE_W = 8;
  typedef struct packed {
    logic [N_BYTES-1:0][BYTE_W-1:0] a;
    logic [15:0]                    b;
  } frame_t;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
endpackage

// File: rtl/byte_frame_packer.sv
// byte_frame_packer: packs up to 8 bytes into a frame with byte count and XOR checksum
module byte_frame_packer
  import frame_pkg::*;
#(
  parameter bit FIRST_HIGH = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] out_frame
);
  state_t     state, state_n;
  frame_t     frame, frame_n;
  logic [2:0] cnt, cnt_n, k, idx;
  logic [7:0] csum, csum_n;
  logic [3:0] len;
  logic       start, acc, close;
  assign out_valid = state == HOLD;
  assign in_ready  = !out_valid || out_ready;
  assign out_frame = frame;
  // The output register doubles as the build buffer; a byte accepted outside FILL opens a fresh frame.
  always_comb begin
    start   = state != FILL;
    acc     = in_valid && in_ready;
    k       = start ? 3'd0 : cnt;
    idx     = FIRST_HIGH ? 3'd7 - k : k;
    close   = in_last || k == 3'd7;
    len     = {1'b0, k} + 4'd1;
    state_n = state;
    frame_n = frame;
    cnt_n   = cnt;
    csum_n  = csum;
    if (acc) begin
      cnt_n           = k + 3'd1;
      csum_n          = (start ? 8'h00 : csum) ^ in_data;
      frame_n.a       = start ? '0 : frame.a;
      frame_n.a[idx]  = in_data;
      frame_n.b       = {4'h0, len, csum_n};
      state_n         = close ? HOLD : FILL;
    end else begin
      state_n = (out_valid && out_ready) ? IDLE : state;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      cnt   <= '0;
      csum  <= '0;
    end else begin
      state <= state_n;
      frame <= frame_n;
      cnt   <= cnt_n;
      csum  <= csum_n;
    end
  end
endmodule

// File: tb/tb_byte_frame_packer.sv
// tb_byte_frame_packer: checks both FIRST_HIGH variants against a byte-list frame model
module tb_byte_frame_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        ir0, ir1, ov0, ov1;
  logic [79:0] of0, of1;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  mb[8];
  int          mn = 0;
  bit          mv = 1'b0;
  bit          acc_flag = 1'b0;
  logic [79:0] mf0, mf1;
  logic [79:0] log0[$];
  logic [79:0] log1[$];

  byte_frame_packer #(.FIRST_HIGH(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_frame(of0));
  byte_frame_packer #(.FIRST_HIGH(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_frame(of1));

  initial forever #5 clk = ~clk;

  function automatic logic [79:0] build(input int fh);
    logic [79:0] f;
    logic [7:0]  x;
    f = '0;
    x = 8'h00;
    for (int i = 0; i < mn; i++) begin
      int p;
      p = fh != 0 ? 7 - i : i;
      f[16 + 8*p +: 8] = mb[i];
      x ^= mb[i];
    end
    f[15:8] = 8'(mn);
    f[7:0]  = x;
    return f;
  endfunction

  // Model: a frame is the list of accepted bytes, closed by in_last or the eighth byte.
  initial forever begin
    bit rdy;
    @(posedge clk or posedge rst);
    acc_flag = 1'b0;
    if (rst) begin
      mn = 0;
      mv = 1'b0;
    end else begin
      rdy = !mv || out_ready;
      if (mv && out_ready) begin
        log0.push_back(mf0);
        log1.push_back(mf1);
        mv = 1'b0;
      end
      if (in_valid && rdy) begin
        acc_flag = 1'b1;
        mb[mn] = in_data;
        mn++;
        if (in_last || mn == 8) begin
          mf0 = build(0);
          mf1 = build(1);
          mv  = 1'b1;
          mn  = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int fh, input int i, input logic [79:0] exp);
    int sz;
    sz = fh != 0 ? log1.size() : log0.size();
    if (i >= sz) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no frame want %h", nm, exp);
    end else begin
      chk(nm, fh != 0 ? log1[i] : log0[i], exp);
    end
  endtask

  initial forever begin
    bit er;
    @(negedge clk);
    er = !mv || out_ready;
    chk("in_ready0", {79'b0, ir0}, {79'b0, er});
    chk("in_ready1", {79'b0, ir1}, {79'b0, er});
    chk("out_valid0", {79'b0, ov0}, {79'b0, mv});
    chk("out_valid1", {79'b0, ov1}, {79'b0, mv});
    if (mv) begin
      chk("out_frame0", of0, mf0);
      chk("out_frame1", of1, mf1);
    end
  end

  task automatic send(input logic [7:0] d, input bit l);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!acc_flag && t < 50);
    if (!acc_flag) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no handshake want byte %h accepted", d);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] seq[8];
    int n, n2;
    seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    #2 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_frame", of0, 80'h0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(seq[i], 1'b0);
    idle(3);
    chk_log("eight_low", 0, 0, 80'hF0DE_BC9A_7856_3412_0800);
    chk_log("eight_high", 1, 0, 80'h1234_5678_9ABC_DEF0_0800);
    n = log0.size();
    send(8'h42, 1'b0);
    send(8'h17, 1'b1);
    idle(3);
    chk_log("two_low", 0, n, 80'h0000_0000_0000_1742_0255);
    chk_log("two_high", 1, n, 80'h4217_0000_0000_0000_0255);
    n = log0.size();
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", {79'b0, ir0}, 80'h0);
      chk("stall_frame", of0, 80'h0000_0000_0000_2211_0233);
    end
    out_ready = 1'b1;
    send(8'hAA, 1'b1);
    idle(3);
    chk_log("stall_old", 0, n, 80'h0000_0000_0000_2211_0233);
    chk_log("stall_new", 0, n + 1, 80'h0000_0000_0000_00AA_01AA);
    n = log0.size();
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_valid", {79'b0, ov0}, 80'h0);
      chk("rst_mid_frame", of1, 80'h0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    idle(3);
    chk("rst_frames", 80'(log0.size()), 80'(n + 1));
    chk_log("rst_after", 0, n, 80'h0000_0000_0000_0201_0203);
    n = log0.size();
    send(8'hFF, 1'b1);
    idle(3);
    chk_log("single_ff", 0, n, 80'h0000_0000_0000_00FF_01FF);
    n2 = log0.size();
    idle(10);
    chk("quiet_frames", 80'(log0.size()), 80'(n2));
    chk("quiet_valid", {79'b0, ov0}, 80'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/byte_frame_packer.md
BYTE_FRAME_PACKER -- requirements
Module: byte_frame_packer

Interface
REQ-001 SHALL have parameter: FIRST_HIGH, default 0, meaning 0 = first byte lands in a[0] (least significant element) and 1 = first byte lands in a[7].
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  byte offered.
REQ-005 SHALL have port: in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-006 SHALL have port: in_data  input  8  byte value.
REQ-007 SHALL have port: in_last  input  1  accepted byte closes the frame.
REQ-008 SHALL have port: out_valid  output  1  frame available.
REQ-009 SHALL have port: out_ready  input  1  frame consumed when out_valid && out_ready.
REQ-010 SHALL have port: out_frame  output  80  packed frame_t {bit [7:0][7:0] a; bit [15:0] b}, with a in bits 79:16.

Function
REQ-011 SHALL use three states: IDLE (no bytes held), FILL (1-7 bytes held), HOLD (frame complete, out_valid=1).
REQ-012 SHALL drive in_ready = !out_valid || out_ready; this combinational path from out_ready is intended.
REQ-013 SHALL write accepted byte number k (k=0..7, counted from frame start) to a[k] when FIRST_HIGH=0, or to a[7-k] when FIRST_HIGH=1.
REQ-014 SHALL close a frame when the accepted byte has in_last=1 or is the 8th byte (k=7); the frame is in out_frame with out_valid=1 on the next cycle (latency 1 from the closing handshake).
REQ-015 SHALL hold a elements not written in the current frame at 8'h00.
REQ-016 SHALL set b[15:8] = number of bytes in the frame (1..8) and b[7:0] = XOR of all bytes in the frame.
REQ-017 SHALL keep out_frame and out_valid stable in HOLD until out_ready=1.
REQ-018 SHALL, on a cycle with both the output handshake and an input handshake, emit the old frame and start a new frame with that byte as k=0 (a cleared, count=1, checksum=byte); there is no bubble.
REQ-019 SHALL treat in_last on byte k=7 identically to an 8-byte close; in_last is ignored when in_valid=0.
REQ-020 SHALL not change state or data while in_valid=0 in IDLE or FILL.
REQ-021 SHALL never produce a zero-byte frame.

Reset
REQ-022 SHALL, on rst=1 (asynchronously): set state=IDLE, out_valid=0, out_frame=80'h0, byte counter=0, checksum=0.
REQ-023 SHALL discard a partial frame on reset mid-FILL, and SHALL drop a held, unconsumed frame on reset mid-HOLD.
REQ-024 SHALL drive in_ready=1 during and immediately after reset.

Structure
REQ-025 SHALL take frame_t, N_BYTES=8 and BYTE_W=8 from shared package frame_pkg, which the downstream consumer of out_frame also imports.
REQ-026 SHALL update a elements by indexed assignment into the packed struct field (out_frame.a[idx]), not by manual bit-offset arithmetic.
REQ-027 SHALL be a single module with no sub-module; the counter, checksum and FSM are local.

Verification
REQ-028 SHALL cover FIRST_HIGH=0, bytes 12,34,56,78,9A,BC,DE,F0 back-to-back, out_ready=1 -> one frame, out_frame=80'hF0DE_BC9A_7856_3412_0800.
REQ-029 SHALL cover FIRST_HIGH=0, bytes 42,17 with in_last on 17 -> out_frame=80'h0000_0000_0000_1742_0255.
REQ-030 SHALL cover FIRST_HIGH=1, the same 8 bytes as REQ-028 -> out_frame=80'h1234_5678_9ABC_DEF0_0800.
REQ-031 SHALL cover out_ready=0 for 5 cycles after a frame closes -> in_ready=0, out_frame unchanged, then with out_ready=1 and byte AA offered -> old frame emitted, new frame starts with AA (a 1-byte frame AA closed by in_last yields 80'h0000_0000_0000_00AA_01AA).
REQ-032 SHALL cover rst asserted asynchronously mid-edge after 3 bytes, then bytes 01,02 with in_last on 02 -> only frame seen is 80'h0000_0000_0000_0201_0203; out_valid=0 throughout reset.
REQ-033 SHALL cover a single byte FF with in_last -> out_frame=80'h0000_0000_0000_00FF_01FF; then in_valid held low for 10 cycles -> no further out_valid.
